hazard_forward_unit: RTL and testbench

//  Sits in the ID->EX boundary of the 5-stage RV32I pipeline and drives the select lines of the EX-stage operand forwarding mux.

---
 rtl/hazard_forward_unit.sv | 91 +++++++++
 tb/tb_hazard_forward_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding select, load-use stall/bubble control and a
// saturating load-use stall counter for the 5-stage RV32I pipeline.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush_ex,
    input  logic                  mem_stall,
    output logic [1:0]            forward_rs1,
    output logic [1:0]            forward_rs2,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic [CNT_W-1:0]      load_use_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } mem_stage_t;

    ex_stage_t  ex_q;
    mem_stage_t mem_q;

    logic m1, m2, w1, w2, load_use;
    logic [1:0] fwd1_d, fwd2_d;

    always_comb begin
        m1 = ex_q.valid & ex_q.reg_write & (ex_q.rd != '0) & id_rs1_used & (id_rs1 == ex_q.rd);
        m2 = ex_q.valid & ex_q.reg_write & (ex_q.rd != '0) & id_rs2_used & (id_rs2 == ex_q.rd);
        w1 = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0) & id_rs1_used & (id_rs1 == mem_q.rd);
        w2 = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0) & id_rs2_used & (id_rs2 == mem_q.rd);
        load_use = id_valid & ex_q.mem_read & (m1 | m2);
        // Youngest producer wins; an invalid ID slot never selects a bypass.
        fwd1_d = 2'b00;
        fwd2_d = 2'b00;
        if (id_valid) begin
            fwd1_d = m1 ? 2'b01 : (w1 ? 2'b10 : 2'b00);
            fwd2_d = m2 ? 2'b01 : (w2 ? 2'b10 : 2'b00);
        end
    end

    assign stall_if_id = load_use & ~flush_ex & ~mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            forward_rs1  <= 2'b00;
            forward_rs2  <= 2'b00;
            bubble_ex    <= 1'b0;
            load_use_cnt <= '0;
        end else if (mem_stall) begin
            // Global freeze: everything holds, a pending flush waits for release.
        end else begin
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
            if (flush_ex || load_use) begin
                ex_q.valid  <= 1'b0;
                bubble_ex   <= 1'b1;
                forward_rs1 <= 2'b00;
                forward_rs2 <= 2'b00;
                if (!flush_ex && (load_use_cnt != {CNT_W{1'b1}}))
                    load_use_cnt <= load_use_cnt + 1'b1;
            end else begin
                ex_q        <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                                 mem_read: id_mem_read};
                bubble_ex   <= 1'b0;
                forward_rs1 <= fwd1_d;
                forward_rs2 <= fwd2_d;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven bench for hazard_forward_unit (CNT_W=4 so the
// counter saturation is reachable quickly).
module tb_hazard_forward_unit;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk, rst_n;
    logic          id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          flush_ex, mem_stall;
    logic [1:0]    forward_rs1, forward_rs2;
    logic          stall_if_id, bubble_ex;
    logic [CW-1:0] load_use_cnt;

    hazard_forward_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush_ex(flush_ex),
        .mem_stall(mem_stall), .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .load_use_cnt(load_use_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [RW-1:0] rs1, rs2;
        logic          u1, u2;
        logic [RW-1:0] rd;
        logic          rw, mr, fl, ms;
        logic          e_stall;
        logic [1:0]    e_f1, e_f2;
        logic          e_bub;
        logic [CW-1:0] e_cnt;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw,
                                bit mr, bit fl, bit ms, bit es, int f1, int f2, bit eb, int ec);
        vec_t r;
        r.v = v; r.rs1 = RW'(rs1); r.rs2 = RW'(rs2); r.u1 = u1; r.u2 = u2;
        r.rd = RW'(rd); r.rw = rw; r.mr = mr; r.fl = fl; r.ms = ms;
        r.e_stall = es; r.e_f1 = 2'(f1); r.e_f2 = 2'(f2); r.e_bub = eb; r.e_cnt = CW'(ec);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rs1_used = x.u1; id_rs2_used = x.u2;
        id_rd = x.rd; id_reg_write = x.rw; id_mem_read = x.mr; flush_ex = x.fl; mem_stall = x.ms;
    endtask

    // Entered and left at posedge+1: stall checked mid-cycle, registers after the edge.
    task automatic run(input vec_t x, input string tag);
        apply(x);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall_if_id), 32'(x.e_stall));
        @(posedge clk);
        #1;
        chk({tag, ".fwd1"}, 32'(forward_rs1), 32'(x.e_f1));
        chk({tag, ".fwd2"}, 32'(forward_rs2), 32'(x.e_f2));
        chk({tag, ".bubble"}, 32'(bubble_ex), 32'(x.e_bub));
        chk({tag, ".cnt"}, 32'(load_use_cnt), 32'(x.e_cnt));
    endtask

    vec_t tbl[12];
    vec_t idle;

    initial begin
        //            v rs1 rs2 u1 u2 rd rw mr fl ms | stall f1 f2 bub cnt
        tbl[0]  = mk(1, 1,  2,  1, 1, 5, 1, 0, 0, 0,   0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 5,  6,  1, 1, 8, 1, 0, 0, 0,   0,   1, 0, 0, 0);
        tbl[2]  = mk(1, 1,  5,  1, 1, 7, 1, 0, 0, 0,   0,   0, 2, 0, 0);
        tbl[3]  = mk(1, 0,  0,  0, 0, 7, 1, 0, 0, 0,   0,   0, 0, 0, 0);
        tbl[4]  = mk(1, 7,  7,  1, 1, 0, 1, 0, 0, 0,   0,   1, 1, 0, 0);
        tbl[5]  = mk(1, 0,  0,  1, 1, 0, 1, 0, 0, 0,   0,   0, 0, 0, 0);
        tbl[6]  = mk(1, 0,  0,  1, 1, 3, 1, 1, 0, 0,   0,   0, 0, 0, 0);
        tbl[7]  = mk(1, 3,  4,  1, 1, 9, 1, 0, 0, 0,   1,   0, 0, 1, 1);
        tbl[8]  = mk(1, 3,  4,  1, 1, 9, 1, 0, 0, 0,   0,   2, 0, 0, 1);
        tbl[9]  = mk(1, 9,  0,  1, 0, 4, 1, 1, 0, 0,   0,   1, 0, 0, 1);
        tbl[10] = mk(1, 4,  0,  1, 0, 12, 1, 0, 1, 0,  0,   0, 0, 1, 1);
        tbl[11] = mk(0, 4,  0,  1, 0, 12, 1, 0, 0, 0,  0,   0, 0, 0, 1);
        idle    = mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0);

        rst_n = 1'b0;
        apply(idle);
        #7;
        chk("reset.fwd1", 32'(forward_rs1), 0);
        chk("reset.fwd2", 32'(forward_rs2), 0);
        chk("reset.bubble", 32'(bubble_ex), 0);
        chk("reset.cnt", 32'(load_use_cnt), 0);
        chk("reset.stall", 32'(stall_if_id), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("tbl%0d", i));

        // Memory freeze over a pending load-use: nothing moves, then one stall.
        run(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 1), "ms.pre");
        run(mk(1, 14, 0, 1, 0, 10, 1, 1, 0, 0, 0, 1, 0, 0, 1), "ms.lw");
        for (int i = 0; i < 3; i++)
            run(mk(1, 0, 10, 0, 1, 13, 1, 0, 0, 1, 0, 1, 0, 0, 1), $sformatf("ms.hold%0d", i));
        run(mk(1, 0, 10, 0, 1, 13, 1, 0, 0, 0, 1, 0, 0, 1, 2), "ms.stall");
        run(mk(1, 0, 10, 0, 1, 13, 1, 0, 0, 0, 0, 0, 2, 0, 2), "ms.resume");

        // Counter saturation: repeated lw/use pairs.
        begin
            int exp_cnt = 2;
            for (int i = 0; i < 16; i++) begin
                run(mk(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0, 0, exp_cnt), $sformatf("sat.lw%0d", i));
                exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
                run(mk(1, 11, 0, 1, 0, 15, 1, 0, 0, 0, 1, 0, 0, 1, exp_cnt), $sformatf("sat.use%0d", i));
            end
            chk("sat.final", 32'(load_use_cnt), 15);
        end

        // Async reset while a bubble is showing, then a clean restart.
        #2 rst_n = 1'b0;
        #1;
        chk("areset.fwd1", 32'(forward_rs1), 0);
        chk("areset.fwd2", 32'(forward_rs2), 0);
        chk("areset.bubble", 32'(bubble_ex), 0);
        chk("areset.cnt", 32'(load_use_cnt), 0);
        chk("areset.stall", 32'(stall_if_id), 0);
        apply(idle);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0), "restart.prod");
        run(mk(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0), "restart.cons");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
